// File: rtl/mem_stage.sv
// mem_stage: memory-access stage. Launches loads/stores on the data bus via a
// req/gnt/rvalid handshake, aligns and extends load data, stalls upstream while
// an access is in flight, and registers the write-back triple.
//
// state | meaning
// IDLE  | no access in flight; a valid aligned memory op launches one
// REQ   | bus request held with latched fields until grant
// WAIT  | load granted, waiting for read data
// DONE  | access complete; write-back loaded on this edge, upstream advances
module mem_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
  input  logic                   mem_we_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [3:0]             mem_op_i,
  output logic                   dbus_req_o,
  input  logic                   dbus_gnt_i,
  output logic                   dbus_we_o,
  output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
  output logic [3:0]             dbus_be_o,
  output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
  input  logic                   dbus_rvalid_i,
  input  logic [DATA_WIDTH-1:0]  dbus_rdata_i,
  output logic                   stall_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [DATA_WIDTH-1:0]  reg_wdata_o,
  output logic                   misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t state, state_nxt;

  logic                   is_load, is_store, is_mem, misaligned, launch;
  logic [1:0]             size, offset;
  logic [3:0]             be;
  logic [DATA_WIDTH-1:0]  wdata;

  logic [3:0]             op_q;
  logic                   store_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [3:0]             be_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [RADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0]  ldata_q;
  logic [DATA_WIDTH-1:0]  shifted, ext;
  logic                   in_req;

  // mem_we_i duplicates information already carried by mem_op_i
  logic unused_we;
  assign unused_we = mem_we_i;

  // Decode the incoming op into direction and access size
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = SZ_BYTE;
    case (mem_op_i)
      OP_LB, OP_LBU: begin is_load  = 1'b1; size = SZ_BYTE; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; size = SZ_HALF; end
      OP_LW:         begin is_load  = 1'b1; size = SZ_WORD; end
      OP_SB:         begin is_store = 1'b1; size = SZ_BYTE; end
      OP_SH:         begin is_store = 1'b1; size = SZ_HALF; end
      OP_SW:         begin is_store = 1'b1; size = SZ_WORD; end
      default:       ;
    endcase
  end

  assign offset     = mem_addr_i[1:0];
  assign is_mem     = is_load | is_store;
  assign misaligned = is_mem && (((size == SZ_HALF) && offset[0]) ||
                                 ((size == SZ_WORD) && (offset != 2'd0)));
  assign launch     = (state == IDLE) && is_mem && !misaligned;
  assign stall_o    = launch || (state == REQ) || (state == WAIT);

  // Byte enables and lane-replicated store data; loads reuse the same enables
  always_comb begin
    be    = 4'b1111;
    wdata = mem_data_i;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << offset;
        wdata = {4{mem_data_i[7:0]}};
      end
      SZ_HALF: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{mem_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Align returned word to bit 0 and extend according to the latched op
  always_comb begin
    shifted = dbus_rdata_i >> {addr_q[1:0], 3'b000};
    case (op_q)
      OP_LB:   ext = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      OP_LBU:  ext = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      OP_LH:   ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      OP_LHU:  ext = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (launch) state_nxt = REQ;
      REQ:  if (dbus_gnt_i) state_nxt = store_q ? DONE : WAIT;
      WAIT: if (dbus_rvalid_i) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the access at launch and the extended read data on rvalid
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q    <= '0;
      store_q <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      ldata_q <= '0;
    end else begin
      if (launch) begin
        op_q    <= mem_op_i;
        store_q <= is_store;
        addr_q  <= mem_addr_i;
        be_q    <= be;
        wdata_q <= wdata;
        waddr_q <= reg_waddr_i;
      end
      if ((state == WAIT) && dbus_rvalid_i) ldata_q <= ext;
    end
  end

  // Bus fields are forced to zero outside REQ so reset drops them immediately
  assign in_req       = (state == REQ);
  assign dbus_req_o   = in_req;
  assign dbus_we_o    = in_req && store_q;
  assign dbus_addr_o  = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign dbus_be_o    = in_req ? be_q : 4'b0000;
  assign dbus_wdata_o = in_req ? wdata_q : '0;

  // Write-back register: bubble while stalled, otherwise pass-through,
  // load result, store bubble or misalignment flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      reg_waddr_o <= '0;
      reg_we_o    <= 1'b0;
      reg_wdata_o <= '0;
      misalign_o  <= 1'b0;
    end else begin
      reg_waddr_o <= '0;
      reg_we_o    <= 1'b0;
      reg_wdata_o <= '0;
      misalign_o  <= 1'b0;
      if (!stall_o) begin
        if (state == IDLE) begin
          if (misaligned) begin
            misalign_o <= 1'b1;
          end else begin
            reg_waddr_o <= reg_waddr_i;
            reg_we_o    <= reg_we_i;
            reg_wdata_o <= reg_wdata_i;
          end
        end else if ((state == DONE) && !store_q) begin
          reg_waddr_o <= waddr_q;
          reg_we_o    <= 1'b1;
          reg_wdata_o <= ldata_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage. A driver issues ops
// and pushes expected bus accesses and write-backs; a bus responder and a
// write-back monitor pop and compare independently.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  reg_waddr;
  logic        reg_we;
  logic [31:0] reg_wdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_op;
  logic        dbus_req, dbus_gnt, dbus_we, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        stall;
  logic [4:0]  wb_waddr;
  logic        wb_we;
  logic [31:0] wb_wdata;
  logic        misalign;

  mem_stage dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .reg_waddr_i(reg_waddr), .reg_we_i(reg_we), .reg_wdata_i(reg_wdata),
    .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_data_i(mem_data), .mem_op_i(mem_op),
    .dbus_req_o(dbus_req), .dbus_gnt_i(dbus_gnt), .dbus_we_o(dbus_we),
    .dbus_addr_o(dbus_addr), .dbus_be_o(dbus_be), .dbus_wdata_o(dbus_wdata),
    .dbus_rvalid_i(dbus_rvalid), .dbus_rdata_i(dbus_rdata),
    .stall_o(stall),
    .reg_waddr_o(wb_waddr), .reg_we_o(wb_we), .reg_wdata_o(wb_wdata),
    .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic        mis;
  } wb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          gdelay;
    int          rdelay;
    logic [31:0] rdata;
  } bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;
  bit   hold_gnt = 1'b0;
  bit   hold_resp = 1'b0;
  bit   force_rvalid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: kind 0 = non-memory, 1 = load, 2 = store, 3 = misaligned
  function automatic void model(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] data, input logic [31:0] rdata,
                                output int kind, output logic [3:0] be,
                                output logic [31:0] wdata, output logic [31:0] ld);
    int nbytes, off;
    bit sgn;
    logic [31:0] v;
    nbytes = 0; sgn = 0; kind = 0;
    case (op)
      4'd1: begin nbytes = 1; sgn = 1; kind = 1; end
      4'd2: begin nbytes = 2; sgn = 1; kind = 1; end
      4'd3: begin nbytes = 4; kind = 1; end
      4'd4: begin nbytes = 1; kind = 1; end
      4'd5: begin nbytes = 2; kind = 1; end
      4'd6: begin nbytes = 1; kind = 2; end
      4'd7: begin nbytes = 2; kind = 2; end
      4'd8: begin nbytes = 4; kind = 2; end
      default: kind = 0;
    endcase
    off = int'(addr % 4);
    be = 4'b0; wdata = 32'b0; ld = 32'b0;
    if (kind != 0 && (off % nbytes) != 0) kind = 3;
    if (kind == 1 || kind == 2) begin
      be = 4'(((1 << nbytes) - 1) << off);
      if (nbytes == 1)      wdata = (data & 32'hFF) * 32'h0101_0101;
      else if (nbytes == 2) wdata = (data & 32'hFFFF) * 32'h0001_0001;
      else                  wdata = data;
      v = rdata >> (8 * off);
      if (nbytes < 4) begin
        v = v & ((32'd1 << (8 * nbytes)) - 32'd1);
        if (sgn && v >= (32'd1 << (8 * nbytes - 1))) v = v - (32'd1 << (8 * nbytes));
      end
      ld = v;
    end
  endfunction

  // Issue one op at posedge+1, wait until the stage accepts it, return at posedge+1
  task automatic issue(input logic [3:0] op, input logic [4:0] wa, input logic we,
                       input logic [31:0] wd, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] rdata,
                       input int gd, input int rdl);
    int kind, cnt;
    logic [3:0] be;
    logic [31:0] wdata, ld;
    wb_t w;
    bus_t b;
    model(op, addr, data, rdata, kind, be, wdata, ld);
    case (kind)
      0: w = '{waddr: wa, we: we, wdata: wd, mis: 1'b0};
      1: w = '{waddr: wa, we: 1'b1, wdata: ld, mis: 1'b0};
      2: w = '{waddr: 5'd0, we: 1'b0, wdata: 32'd0, mis: 1'b0};
      default: w = '{waddr: 5'd0, we: 1'b0, wdata: 32'd0, mis: 1'b1};
    endcase
    wb_q.push_back(w);
    if (kind == 1 || kind == 2) begin
      b = '{we: (kind == 2), addr: addr & 32'hFFFF_FFFC, be: be, wdata: wdata,
            gdelay: gd, rdelay: rdl, rdata: rdata};
      bus_q.push_back(b);
    end
    mem_op = op; reg_waddr = wa; reg_we = we; reg_wdata = wd;
    mem_addr = addr; mem_data = data; mem_we = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("stall_on_issue", {63'd0, stall}, {63'd0, (kind == 1 || kind == 2)});
    cnt = 0;
    while (stall && cnt < 64) begin
      @(negedge clk);
      cnt++;
    end
    if (stall) begin
      errors++;
      $display("FAIL stall_timeout: got stall=1 after %0d cycles expected release", cnt);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "stall timeout");
    end
    @(posedge clk); #1;
  endtask

  // Write-back monitor: each edge with stall low retires one op, else a bubble
  bit  m_have_prev = 1'b0;
  bit  m_prev_stall = 1'b0;
  wb_t m_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        m_have_prev = 1'b0;
      end else begin
        if (m_have_prev) begin
          if (m_prev_stall) begin
            check("wb_bubble", {25'd0, wb_waddr, wb_we, wb_wdata, misalign}, 64'd0);
          end else if (wb_q.size() == 0) begin
            check("wb_unexpected_we", {63'd0, wb_we}, 64'd0);
          end else begin
            m_exp = wb_q.pop_front();
            check("wb_waddr", {59'd0, wb_waddr}, {59'd0, m_exp.waddr});
            check("wb_we", {63'd0, wb_we}, {63'd0, m_exp.we});
            check("wb_wdata", {32'd0, wb_wdata}, {32'd0, m_exp.wdata});
            check("misalign", {63'd0, misalign}, {63'd0, m_exp.mis});
          end
        end
        m_prev_stall = stall;
        m_have_prev = 1'b1;
      end
    end
  end

  // Bus responder: checks request fields, grants and returns read data
  bit   r_active = 1'b0;
  bit   r_waiting = 1'b0;
  int   r_gcnt = 0;
  int   r_cnt = 0;
  bus_t r_cur;
  initial begin
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        r_active = 1'b0; r_waiting = 1'b0;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
      end else if (r_waiting) begin
        dbus_gnt = 1'b0;
        if (!hold_resp && r_cnt == 0) begin
          dbus_rvalid = 1'b1; dbus_rdata = r_cur.rdata; r_waiting = 1'b0;
        end else begin
          dbus_rvalid = 1'b0; dbus_rdata = $urandom;
          if (r_cnt > 0) r_cnt--;
        end
      end else if (force_rvalid) begin
        dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = $urandom;
      end else if (dbus_req) begin
        if (!r_active && bus_q.size() == 0) begin
          check("bus_req_expected", {63'd0, dbus_req}, 64'd0);
          dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        end else begin
          if (!r_active) begin
            r_cur = bus_q.pop_front();
            r_active = 1'b1;
            r_gcnt = r_cur.gdelay;
          end
          check("bus_we", {63'd0, dbus_we}, {63'd0, r_cur.we});
          check("bus_addr", {32'd0, dbus_addr}, {32'd0, r_cur.addr});
          check("bus_be", {60'd0, dbus_be}, {60'd0, r_cur.be});
          if (r_cur.we) check("bus_wdata", {32'd0, dbus_wdata}, {32'd0, r_cur.wdata});
          if (!hold_gnt && r_gcnt == 0) begin
            dbus_gnt = 1'b1; dbus_rvalid = 1'b0; r_active = 1'b0;
            if (!r_cur.we) begin r_waiting = 1'b1; r_cnt = r_cur.rdelay; end
          end else begin
            dbus_gnt = 1'b0;
            dbus_rvalid = 1'($urandom_range(0, 1));
            dbus_rdata = $urandom;
            if (r_gcnt > 0) r_gcnt--;
          end
        end
      end else begin
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        check("bus_idle_zero", {dbus_we, dbus_addr, dbus_be, dbus_wdata},
              {1'b0, 32'd0, 4'd0, 32'd0});
      end
    end
  end

  // Stimulus
  initial begin
    logic [3:0]  op;
    logic [31:0] addr;
    int          cnt;

    mem_op = 4'd0; reg_waddr = 5'd0; reg_we = 1'b0; reg_wdata = 32'd0;
    mem_addr = 32'd0; mem_data = 32'd0; mem_we = 1'b0;

    #12;
    check("rst_wb", {25'd0, wb_waddr, wb_we, wb_wdata, misalign}, 64'd0);
    check("rst_req", {63'd0, dbus_req}, 64'd0);
    check("rst_stall_nop", {63'd0, stall}, 64'd0);
    mem_op = 4'd3;
    #1;
    check("rst_stall_lw", {63'd0, stall}, 64'd1);
    mem_op = 4'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases
    issue(4'd0, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0, 32'h0, 0, 0);
    issue(4'd1, 5'd7, 1'b0, 32'h0, 32'h1003, 32'h0, 32'h80FF_FF00, 2, 0);
    issue(4'd4, 5'd8, 1'b0, 32'h0, 32'h1003, 32'h0, 32'h80FF_FF00, 0, 1);
    issue(4'd7, 5'd9, 1'b1, 32'h0, 32'h2002, 32'hABCD_5678, 32'h0, 3, 0);
    issue(4'd3, 5'd10, 1'b1, 32'h0, 32'h3001, 32'h0, 32'h0, 0, 0);
    issue(4'd3, 5'd11, 1'b0, 32'h0, 32'h3000, 32'h0, 32'hCAFE_F00D, 1, 2);
    issue(4'd0, 5'd12, 1'b1, 32'h5555, 32'h0, 32'h0, 32'h0, 0, 0);

    // Randomized mix
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 3) op = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
      else op = 4'($urandom_range(1, 8));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (op == 4'd3 || op == 4'd8) addr[1:0] = 2'b00;
        if (op == 4'd2 || op == 4'd5 || op == 4'd7) addr[0] = 1'b0;
      end
      issue(op, 5'($urandom), 1'($urandom_range(0, 1)), $urandom, addr, $urandom,
            $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    mem_op = 4'd0; reg_we = 1'b0;
    @(negedge clk); #1;
    mon_en = 1'b0;
    check("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    check("bus_queue_drained", 64'(bus_q.size()), 64'd0);

    // Reset while the request is held: req must drop without a clock edge
    @(posedge clk); #1;
    hold_gnt = 1'b1;
    bus_q.push_back('{we: 1'b0, addr: 32'h4000, be: 4'hF, wdata: 32'd0, gdelay: 0, rdelay: 0, rdata: 32'd0});
    mem_op = 4'd3; mem_addr = 32'h4000; reg_waddr = 5'd3;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!dbus_req && cnt < 10);
    check("abort_req_seen", {63'd0, dbus_req}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_req_drop", {63'd0, dbus_req}, 64'd0);
    check("abort_stall_in_rst", {63'd0, stall}, 64'd1);
    @(posedge clk); #2;
    hold_gnt = 1'b0; hold_resp = 1'b1;
    bus_q.delete();
    bus_q.push_back('{we: 1'b0, addr: 32'h4000, be: 4'hF, wdata: 32'd0, gdelay: 0, rdelay: 0, rdata: 32'hFFFF_FFFF});
    rst_n = 1'b1;

    // Reset while waiting for read data: no write-back may follow
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!dbus_gnt && cnt < 10);
    check("wait_gnt_seen", {63'd0, dbus_gnt}, 64'd1);
    @(negedge clk);
    check("wait_stall", {63'd0, stall}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("wait_rst_req", {63'd0, dbus_req}, 64'd0);
    check("wait_rst_wb", {25'd0, wb_waddr, wb_we, wb_wdata, misalign}, 64'd0);
    mem_op = 4'd0; reg_we = 1'b0;
    hold_resp = 1'b0; force_rvalid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("late_rvalid_no_wb", {62'd0, wb_we, misalign}, 64'd0);
      check("late_rvalid_idle", {62'd0, stall, dbus_req}, 64'd0);
    end
    force_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV32 pipeline, directly downstream of the execute stage. It consumes the execute results (register write-back triple plus memory address, data, write enable and op code) and performs loads and stores on the data bus through a request/grant/response handshake. It aligns and extends load data, stalls the upstream pipeline while an access is outstanding, and presents a registered write-back triple to the write-back stage.

## Interface
- DATA_WIDTH, 32, data and register-file word width
- ADDR_WIDTH, 32, byte address width
- RADDR_WIDTH, 5, register index width
- clk_i  in  1  clock; all state updates on the rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- reg_waddr_i  in  RADDR_WIDTH  destination register from execute
- reg_we_i  in  1  register write enable from execute
- reg_wdata_i  in  DATA_WIDTH  ALU result from execute; unused for loads
- mem_we_i  in  1  store indicator; redundant with mem_op_i, ignored
- mem_addr_i  in  ADDR_WIDTH  effective byte address
- mem_data_i  in  DATA_WIDTH  store data, right-aligned
- mem_op_i  in  4  encoding: 0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; values 9–15 are treated as NOP
- dbus_req_o  out  1  bus request
- dbus_gnt_i  in  1  bus grant; the request is accepted in a cycle where req and gnt are both high
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  ADDR_WIDTH  word address, {mem_addr[31:2], 2'b00}
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  DATA_WIDTH  lane-replicated store data
- dbus_rvalid_i  in  1  read data valid
- dbus_rdata_i  in  DATA_WIDTH  read data word
- stall_o  out  1  combinational; upstream holds all inputs stable while high
- reg_waddr_o / reg_we_o / reg_wdata_o  out  RADDR_WIDTH / 1 / DATA_WIDTH  registered write-back triple
- misalign_o  out  1  registered one-cycle flag for a misaligned access

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE → REQ: a valid, aligned memory op is present. The stage latches the op, address, byte enables, write data and waddr.
  - REQ → WAIT: on grant for a load.
  - REQ → DONE: on grant for a store.
  - WAIT → DONE: on dbus_rvalid_i. The stage captures the extended load data.
  - DONE → IDLE: unconditional.
- stall_o = (IDLE and a valid aligned memory op is present) or REQ or WAIT. It is 0 in DONE, so upstream advances after the DONE edge. DONE never relaunches an access.
- dbus_req_o = 1 only in REQ. dbus_we_o, dbus_addr_o, dbus_be_o and dbus_wdata_o come from the latched values and are held stable until grant. They are 0 when not in REQ.
- Byte enables:
  - SB: be = 1 << addr[1:0], wdata = {4{data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111, wdata = data.
  - Loads drive the same be pattern as the matching store width.
- Load data: shift rdata right by addr[1:0]×8, then take a byte or half and sign-extend (LB, LH) or zero-extend (LBU, LHU). LW passes the word through.
- Misalignment: LH, LHU or SH with addr[0] = 1, or LW or SW with addr[1:0] ≠ 0. No bus access and no stall. Next edge: misalign_o = 1, reg_we_o = 0, reg_waddr_o = 0, reg_wdata_o = 0.
- Write-back register updates at every edge where stall_o = 0:
  - IDLE with a non-memory op: latch reg_waddr_i, reg_we_i, reg_wdata_i.
  - DONE after a load: latch the latched waddr, reg_we = 1, and the extended data.
  - DONE after a store: reg_we = 0, waddr = 0, wdata = 0.
- While stall_o = 1 the write-back register loads a bubble: all zeros.
- misalign_o is 0 on every edge except the misalignment case above.
- dbus_rvalid_i outside WAIT is ignored. A grant and rvalid in the same cycle in REQ is not supported; rvalid arrives at least one cycle after the grant.

## Timing
- Reset (asynchronous, rst_n_i = 0): state = IDLE.
  - Registered outputs cleared: reg_waddr_o = 0, reg_we_o = 0, reg_wdata_o = 0, misalign_o = 0.
  - Bus outputs are 0 via state decode: dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o.
  - stall_o still follows its combinational equation: it is 1 if a valid aligned memory op is on the inputs during reset, else 0.
- Reset asserted mid-access abandons the transaction. dbus_req_o drops without waiting for a clock edge. No write-back is produced.
- Non-memory op and misaligned op: 1-cycle latency, no stall.
- Load with grant in the first REQ cycle and rvalid on the next cycle:
  - cycle 0: IDLE, stall.
  - cycle 1: REQ, grant.
  - cycle 2: WAIT, rvalid.
  - cycle 3: DONE, stall_o = 0.
  - Write-back valid in cycle 4.
- Each wait cycle on grant or rvalid adds one cycle.
- Store, best case: outputs a bubble write-back in cycle 3 (IDLE, REQ, DONE).
- Back-to-back memory ops: the next op enters IDLE in the cycle after DONE. Peak rate is one access per 3 cycles.

## Test plan
- Non-memory op: waddr = 5, we = 1, wdata = 0x1234. Next edge: reg_waddr_o = 5, reg_we_o = 1, reg_wdata_o = 0x1234, stall_o = 0 throughout.
- LB at 0x1003, rdata = 0x80FF_FF00, grant delayed 2 cycles:
  - dbus_addr_o = 0x1000, dbus_be_o = 4'b1000.
  - stall_o is held until DONE.
  - reg_wdata_o = 0xFFFF_FF80.
  - LBU on the same data gives 0x0000_0080.
- SH at 0x2002 with data = 0xABCD_5678:
  - dbus_we_o = 1, dbus_be_o = 4'b1100, dbus_wdata_o = 0x5678_5678.
  - reg_we_o = 0.
  - dbus_req_o is held until grant.
- LW at 0x3001: no dbus_req_o. Next edge: misalign_o = 1, reg_we_o = 0, stall_o = 0.
- LW in WAIT, then rst_n_i pulled low:
  - dbus_req_o and all registered outputs are 0 immediately.
  - After release: state is IDLE, and a late rvalid produces no write-back.
- LW followed by an ALU op: the ALU result appears exactly one cycle after the load write-back. rvalid pulses asserted while in REQ are ignored.
